// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster generator: test-pattern mode encodings,
// standard timing sets and a helper that sums one axis into its total period.
// No ports (package).
// ----------------------------------------------------------------------------
package vga_pkg;

    // Pixel source selection, sampled once per frame.
    typedef enum logic [1:0] {
        ModeExt   = 2'd0,
        ModeSolid = 2'd1,
        ModeBars  = 2'd2,
        ModeCheck = 2'd3
    } mode_e;

    // One axis of raster timing: visible, front porch, sync, back porch.
    typedef struct packed {
        int unsigned va;
        int unsigned fp;
        int unsigned sp;
        int unsigned bp;
    } axis_timing_t;

    // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs.
    localparam axis_timing_t H_800X600 = '{va: 800, fp: 40, sp: 128, bp: 88};
    localparam axis_timing_t V_800X600 = '{va: 600, fp: 1,  sp: 4,   bp: 23};

    // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs.
    localparam axis_timing_t H_640X480 = '{va: 640, fp: 16, sp: 96,  bp: 48};
    localparam axis_timing_t V_640X480 = '{va: 480, fp: 10, sp: 2,   bp: 33};

    function automatic int unsigned calc_total(int unsigned va, int unsigned fp,
                                               int unsigned sp, int unsigned bp);
        return va + fp + sp + bp;
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// ----------------------------------------------------------------------------
// vga_pattern_gen
// Colour source for the raster: selects external pixels, a frame-stepped solid
// colour, eight vertical colour bars or a 16-pixel checkerboard. Purely
// combinational from the stage-1 coordinates except the solid-colour register.
// Ports:
//   clk_i       pixel clock
//   rst_ni      synchronous active-low reset
//   mode_i      pattern select (latched per frame by the caller)
//   step_i      advance the solid colour by one
//   pix_x_i     stage-1 column
//   pix_y_b4_i  bit 4 of the stage-1 line (all the checkerboard needs)
//   rgb_i       external pixel {R,G,B}
//   rgb_o       selected colour {R,G,B}, not yet blanked
// ----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W = 1,
    parameter int unsigned H_VA    = 800
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  mode_e                mode_i,
    input  logic                 step_i,
    input  logic [10:0]          pix_x_i,
    input  logic                 pix_y_b4_i,
    input  logic [3*COLOR_W-1:0] rgb_i,
    output logic [3*COLOR_W-1:0] rgb_o
);

    logic [2:0]  solid_q;
    logic [2:0]  bar_idx;
    logic [14:0] x8;

    // Each 1-bit colour component drives the whole channel.
    function automatic logic [3*COLOR_W-1:0] expand(logic [2:0] c);
        return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            solid_q <= 3'b100;
        end else if (step_i) begin
            solid_q <= solid_q + 3'd1;
        end
    end

    // bar = floor(x*8/H_VA): highest k whose threshold k*H_VA is reached by x*8.
    always_comb begin
        x8      = {1'b0, pix_x_i, 3'b000};
        bar_idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x8 >= 15'(k * H_VA)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        rgb_o = '0;
        unique case (mode_i)
            ModeExt:   rgb_o = rgb_i;
            ModeSolid: rgb_o = expand(solid_q);
            ModeBars:  rgb_o = expand(bar_idx);
            ModeCheck: rgb_o = expand({3{pix_x_i[4] ^ pix_y_b4_i}});
            default:   rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster generator. Stage 0 holds the h/v counters, stage 1
// registers coordinates and strobes for the pixel source, stage 2 registers
// sync, display enable and the blanked colour for the DAC pins, so sync, de and
// colour all trail the counters by exactly two clocks.
// Ports:
//   master_clk  pixel clock, rising edge
//   reset_n     synchronous active-low reset
//   mode        pattern select, taken at the start of each frame
//   rgb_in      external pixel {R,G,B} for the current pix_x/pix_y
//   pix_x/pix_y stage-1 coordinates; pix_act marks the visible area
//   sol/sof     stage-1 start-of-line / start-of-frame strobes
//   frame_cnt   frames completed, wraps 255->0
//   hsync/vsync stage-2 syncs with programmable polarity
//   de/rgb_out  stage-2 display enable and colour (zero while de=0)
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VA      = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SP      = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_VA      = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SP      = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          H_POL     = 1'b1,
    parameter bit          V_POL     = 1'b1,
    parameter int unsigned COLOR_W   = 1,
    parameter int unsigned SOLID_DIV = 256
) (
    input  logic                 master_clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic [10:0]          pix_x,
    output logic [9:0]           pix_y,
    output logic                 pix_act,
    output logic                 sol,
    output logic                 sof,
    output logic [7:0]           frame_cnt,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [3*COLOR_W-1:0] rgb_out
);

    localparam int unsigned H_TOT = calc_total(H_VA, H_FP, H_SP, H_BP);
    localparam int unsigned V_TOT = calc_total(V_VA, V_FP, V_SP, V_BP);

    if (H_TOT > 2048 || H_TOT < 2) begin : g_bad_h_tot
        $error("vga_timing_gen: H_TOT must be 2..2048");
    end
    if (V_TOT > 1024 || V_TOT < 2) begin : g_bad_v_tot
        $error("vga_timing_gen: V_TOT must be 2..1024");
    end
    if (COLOR_W < 1 || COLOR_W > 8) begin : g_bad_color_w
        $error("vga_timing_gen: COLOR_W must be 1..8");
    end
    if (SOLID_DIV < 1 || SOLID_DIV > 256 || (SOLID_DIV & (SOLID_DIV - 1)) != 0)
    begin : g_bad_solid_div
        $error("vga_timing_gen: SOLID_DIV must be a power of two in 1..256");
    end

    // Compares run one bit wider so a sync end equal to 2048/1024 still fits.
    localparam logic [11:0] H_LAST = 12'(H_TOT - 1);
    localparam logic [11:0] H_VIS  = 12'(H_VA);
    localparam logic [11:0] H_SS   = 12'(H_VA + H_FP);
    localparam logic [11:0] H_SE   = 12'(H_VA + H_FP + H_SP);
    localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
    localparam logic [10:0] V_VIS  = 11'(V_VA);
    localparam logic [10:0] V_SS   = 11'(V_VA + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_VA + V_FP + V_SP);
    localparam logic [7:0]  SOLID_MASK = 8'(SOLID_DIV - 1);

    // Stage 0
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    mode_e       mode_q;
    logic [11:0] h_ext;
    logic [10:0] v_ext;
    logic        h_last, v_last, frame_wrap, frame_start, solid_step;
    logic        act_d, hs_d, vs_d;

    // Stage 1
    logic [10:0] pix_x_q;
    logic [9:0]  pix_y_q;
    logic        act_q, sol_q, sof_q, hs1_q, vs1_q;

    // Stage 2
    logic                 hsync_q, vsync_q, de_q;
    logic [3*COLOR_W-1:0] rgb_q;
    logic [3*COLOR_W-1:0] colour;

    always_comb begin
        h_ext       = {1'b0, h_cnt_q};
        v_ext       = {1'b0, v_cnt_q};
        h_last      = (h_ext == H_LAST);
        v_last      = (v_ext == V_LAST);
        frame_wrap  = h_last && v_last;
        frame_start = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);

        h_cnt_d = h_last ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
        end

        frame_cnt_d = frame_cnt_q + {7'd0, frame_wrap};
        // Step the solid colour when the new frame count lands on a SOLID_DIV boundary.
        solid_step  = frame_wrap && ((frame_cnt_d & SOLID_MASK) == 8'd0);

        act_d = (h_ext < H_VIS) && (v_ext < V_VIS);
        hs_d  = (h_ext >= H_SS) && (h_ext < H_SE);
        vs_d  = (v_ext >= V_SS) && (v_ext < V_SE);
    end

    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            mode_q      <= ModeExt;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            act_q       <= 1'b0;
            sol_q       <= 1'b0;
            sof_q       <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            de_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            // Latched as the first pixel enters stage 1, so the whole frame uses one mode.
            if (frame_start) begin
                mode_q <= mode_e'(mode);
            end

            pix_x_q <= h_cnt_q;
            pix_y_q <= v_cnt_q;
            act_q   <= act_d;
            sol_q   <= (h_cnt_q == 11'd0);
            sof_q   <= frame_start;
            hs1_q   <= hs_d;
            vs1_q   <= vs_d;

            hsync_q <= hs1_q ? H_POL : ~H_POL;
            vsync_q <= vs1_q ? V_POL : ~V_POL;
            de_q    <= act_q;
            rgb_q   <= act_q ? colour : '0;
        end
    end

    vga_pattern_gen #(
        .COLOR_W (COLOR_W),
        .H_VA    (H_VA)
    ) u_pattern (
        .clk_i      (master_clk),
        .rst_ni     (reset_n),
        .mode_i     (mode_q),
        .step_i     (solid_step),
        .pix_x_i    (pix_x_q),
        .pix_y_b4_i (pix_y_q[4]),
        .rgb_i      (rgb_in),
        .rgb_o      (colour)
    );

    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_act   = act_q;
    assign sol       = sol_q;
    assign sof       = sof_q;
    assign frame_cnt = frame_cnt_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generators share clock, reset and mode: A is a tiny positive-sync raster
// with 1-bit colour stepping its solid colour every frame; B is larger,
// negative-sync, 2-bit colour, stepping every second frame. Expected outputs
// come from the raster arithmetic: position = clocks since reset modulo the
// frame period, with stage 1 one clock and the pins two clocks behind.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HIST = 40000;
    localparam int FT_A = 14 * 8;
    localparam int FT_B = 46 * 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [2:0]  ext_rgb;

    logic [10:0] pix_x_a, pix_x_b;
    logic [9:0]  pix_y_a, pix_y_b;
    logic        act_a, sol_a, sof_a, hsync_a, vsync_a, de_a;
    logic        act_b, sol_b, sof_b, hsync_b, vsync_b, de_b;
    logic [7:0]  fcnt_a, fcnt_b;
    logic [2:0]  rgb_in_a, rgb_out_a;
    logic [5:0]  rgb_in_b, rgb_out_b;

    // External sources respond combinationally to the coordinates.
    assign rgb_in_a = ext_rgb ^ pix_x_a[2:0];
    assign rgb_in_b = {ext_rgb, ext_rgb ^ pix_y_b[2:0]};

    int          k;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  hist_mode [0:HIST-1];
    logic [2:0]  hist_ext  [0:HIST-1];

    typedef struct {
        int x1, y1, fcnt, x2, y2, f;
        bit act1, sol1, sof1, hs, vs, de;
    } exp_t;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VA(8), .H_FP(2), .H_SP(3), .H_BP(1),
        .V_VA(4), .V_FP(1), .V_SP(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(1), .SOLID_DIV(1)
    ) dut_a (
        .master_clk (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .rgb_in     (rgb_in_a),
        .pix_x      (pix_x_a),
        .pix_y      (pix_y_a),
        .pix_act    (act_a),
        .sol        (sol_a),
        .sof        (sof_a),
        .frame_cnt  (fcnt_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .de         (de_a),
        .rgb_out    (rgb_out_a)
    );

    vga_timing_gen #(
        .H_VA(40), .H_FP(2), .H_SP(3), .H_BP(1),
        .V_VA(20), .V_FP(1), .V_SP(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(2), .SOLID_DIV(2)
    ) dut_b (
        .master_clk (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .rgb_in     (rgb_in_b),
        .pix_x      (pix_x_b),
        .pix_y      (pix_y_b),
        .pix_act    (act_b),
        .sol        (sol_b),
        .sof        (sof_b),
        .frame_cnt  (fcnt_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .de         (de_b),
        .rgb_out    (rgb_out_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d after reset)", tag, got, exp, k);
        end
    endtask

    // Raster position reached after kk clock edges with reset released.
    function automatic exp_t model(int kk, int hva, int hfp, int hsp, int hbp,
                                   int vva, int vfp, int vsp, int vbp);
        exp_t e;
        int ht, vt, ft, p;
        e  = '{default: 0};
        ht = hva + hfp + hsp + hbp;
        vt = vva + vfp + vsp + vbp;
        ft = ht * vt;
        if (kk >= 1) begin
            p      = kk - 1;
            e.x1   = p % ht;
            e.y1   = (p / ht) % vt;
            e.act1 = (e.x1 < hva) && (e.y1 < vva);
            e.sol1 = (e.x1 == 0);
            e.sof1 = (p % ft) == 0;
            e.fcnt = (kk / ft) % 256;
        end
        if (kk >= 2) begin
            p    = kk - 2;
            e.x2 = p % ht;
            e.y2 = (p / ht) % vt;
            e.f  = p / ft;
            e.de = (e.x2 < hva) && (e.y2 < vva);
            e.hs = (e.x2 >= hva + hfp) && (e.x2 < hva + hfp + hsp);
            e.vs = (e.y2 >= vva + vfp) && (e.y2 < vva + vfp + vsp);
        end
        return e;
    endfunction

    function automatic logic [2:0] pattern(logic [1:0] m, int f, int x, int y, int hva,
                                           int sdiv);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        case (m)
            2'd1:    return 3'((4 + f / sdiv) % 8);
            2'd2:    return 3'((x * 8) / hva);
            default: return {3{xv[4] ^ yv[4]}};
        endcase
    endfunction

    task automatic check_all();
        exp_t        ea, eb;
        logic [1:0]  m;
        logic [2:0]  c, exp_a;
        logic [5:0]  exp_b;

        ea = model(k, 8, 2, 3, 1, 4, 1, 2, 1);
        check("a_pix_x",   32'(pix_x_a), 32'(ea.x1));
        check("a_pix_y",   32'(pix_y_a), 32'(ea.y1));
        check("a_pix_act", 32'(act_a),   32'(ea.act1));
        check("a_sol",     32'(sol_a),   32'(ea.sol1));
        check("a_sof",     32'(sof_a),   32'(ea.sof1));
        check("a_fcnt",    32'(fcnt_a),  32'(ea.fcnt));
        check("a_hsync",   32'(hsync_a), 32'(ea.hs));
        check("a_vsync",   32'(vsync_a), 32'(ea.vs));
        check("a_de",      32'(de_a),    32'(ea.de));
        exp_a = 3'd0;
        if (ea.de) begin
            m = hist_mode[ea.f * FT_A + 1];
            if (m == 2'd0) exp_a = hist_ext[k] ^ 3'(ea.x2);
            else           exp_a = pattern(m, ea.f, ea.x2, ea.y2, 8, 1);
        end
        check("a_rgb", 32'(rgb_out_a), 32'(exp_a));

        eb = model(k, 40, 2, 3, 1, 20, 1, 2, 1);
        check("b_pix_x", 32'(pix_x_b), 32'(eb.x1));
        check("b_pix_y", 32'(pix_y_b), 32'(eb.y1));
        check("b_sof",   32'(sof_b),   32'(eb.sof1));
        check("b_fcnt",  32'(fcnt_b),  32'(eb.fcnt));
        check("b_hsync", 32'(hsync_b), 32'(!eb.hs));
        check("b_vsync", 32'(vsync_b), 32'(!eb.vs));
        check("b_de",    32'(de_b),    32'(eb.de));
        exp_b = 6'd0;
        if (eb.de) begin
            m = hist_mode[eb.f * FT_B + 1];
            if (m == 2'd0) begin
                exp_b = {hist_ext[k], hist_ext[k] ^ 3'(eb.y2)};
            end else begin
                c     = pattern(m, eb.f, eb.x2, eb.y2, 40, 2);
                exp_b = {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
            end
        end
        check("b_rgb", 32'(rgb_out_b), 32'(exp_b));
    endtask

    // One clock: record what the DUTs sample on the edge, then check at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            k = 0;
        end else begin
            k++;
            if (k >= HIST) begin
                $display("FAIL hist_overflow: got %0d expected below %0d", k, HIST);
                $fatal(1, "history buffer exhausted");
            end
            hist_mode[k] = mode;
            hist_ext[k]  = ext_rgb;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit found;
        reset_n = 1'b0;
        mode    = 2'd0;
        ext_rgb = 3'b101;
        k       = 0;
        repeat (3) tick();
        reset_n = 1'b1;

        // External source, constant colour.
        repeat (2 * FT_A) tick();

        // Bars, then checkerboard requested mid-frame.
        mode = 2'd2;
        repeat (FT_A + 40) tick();
        mode = 2'd3;
        repeat (FT_B + 300) tick();

        // Random mode changes and external colours.
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            ext_rgb = 3'($urandom);
            tick();
        end

        // Solid colour stepping through a full frame_cnt wrap of the small raster.
        mode = 2'd1;
        while (k < 260 * FT_A) begin
            ext_rgb = 3'($urandom);
            tick();
        end

        // One-clock reset while hsync is active.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (hsync_a) found = 1'b1;
            else         tick();
        end
        check("hsync_seen", 32'(found), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (FT_B + 200) begin
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            ext_rgb = 3'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
